bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
- Shares one serial shift-and-add-3 binary-to-BCD converter between NREQ requesters.
- Grants requests round-robin and captures the requester's binary operand.
- Drives the converter's new_data/new_ack handshake, waits for its done level, then returns the BCD result tagged with the requester id.
- Sits between client logic (display/telemetry formatters) and the converter instance.

Parameters:
- NREQ, 4, number of requesters (≥2)
- N, 16, binary operand width; must match converter N
- M, 20, BCD result width; must match converter M

Ports:
- clk  in  1  global clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level
- req_data  in  NREQ*N  operands, requester i at bits [i*N +: N]
- req_ack  out  NREQ  one-cycle pulse, operand of requester i captured
- rsp_valid  out  1  one-cycle pulse, result available
- rsp_id  out  $clog2(NREQ)  requester owning rsp_data
- rsp_data  out  M  BCD result
- busy  out  1  high in every state except IDLE
- conv_new_data  out  1  to converter new_data
- conv_data_in  out  N  to converter data_in
- conv_new_ack  in  1  from converter new_ack (combinational from new_data)
- conv_done  in  1  from converter done (level, high in converter DONE)
- conv_data_out  in  M  from converter data_out

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0; all outputs 0; operand, grant and result registers cleared.
- FSM states: IDLE, ISSUE, SETTLE, WAIT_DONE, RESP.
- IDLE:
  - If any req bit is set, grant g = first set bit searching from rr_ptr upward with wrap.
  - Same cycle: req_ack[g]=1; on the clock edge capture op=req_data[g], gid=g, rr_ptr=(g+1) mod NREQ; go to ISSUE.
  - If no req bit is set: stay in IDLE.
- ISSUE:
  - conv_new_data=1 and conv_data_in=op, both held stable.
  - On conv_new_ack=1 go to SETTLE; otherwise remain in ISSUE.
- SETTLE: one cycle; conv_done is ignored, masking the stale done from the converter's prior DONE state. Go to WAIT_DONE.
- WAIT_DONE: on conv_done=1, register rsp_data=conv_data_out and rsp_id=gid; go to RESP.
- RESP: rsp_valid=1 for exactly one cycle; go to IDLE.
- Only one grant is outstanding at a time. req_ack is never asserted outside IDLE.
- Latency, with the converter idle (immediate ack): rsp_valid asserts N+3 cycles after the req_ack cycle.
- Minimum spacing between successive req_ack pulses: N+4 cycles.
- conv_data_in is 0 outside ISSUE. conv_new_data is never asserted outside ISSUE.
- A requester holding req after its ack is a new request; it is arbitrated fairly against the others, with no back-to-back starvation.
- Deasserting req after ack does not cancel the in-flight conversion; the result is still returned.
- Mid-operation reset aborts the conversion with no rsp_valid. The converter shares the reset domain at integration.
- NREQ non-power-of-2: ids ≥ NREQ are never produced; rr_ptr wraps at NREQ.

Optional Feature:
- Macro: BCD_ARB_TIMEOUT_EN.
- Defined:
  - Adds output rsp_err (1 bit, reset 0) and an internal watchdog counter.
  - Counter clears on entry to ISSUE and counts every cycle in ISSUE/SETTLE/WAIT_DONE.
  - If it reaches 2*N+8 before conv_done is seen: go to RESP with rsp_valid=1, rsp_err=1, rsp_data=0, rsp_id=gid.
  - rsp_err is 0 on normal completion.
- Undefined: no rsp_err port and no counter; the controller waits for conv_done indefinitely.

Test Plan:
- Single request, N=16: req[2]=1 with operand 16'd1234 → req_ack[2] pulse; rsp_valid 19 cycles later with rsp_id=2, rsp_data=20'h01234.
- All four req held high, operands 0/9/65535/100 → grants in order 0,1,2,3,0…; results 20'h00000, 20'h00009, 20'h65535, 20'h00100, each with the correct rsp_id.
- Back-to-back single requester: req[1] held high → consecutive req_ack[1] pulses exactly N+4=20 cycles apart.
- Converter model delays new_ack by 5 cycles → conv_new_data and conv_data_in held stable throughout; rsp_valid delayed by exactly 5 cycles.
- rst asserted asynchronously mid-WAIT_DONE → all outputs 0 immediately; no rsp_valid; next request served normally with rr_ptr=0.
- With BCD_ARB_TIMEOUT_EN, converter model never raises done → rsp_valid with rsp_err=1 and rsp_data=0 exactly 2*N+8=40 cycles after ISSUE entry.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one serial binary-to-BCD converter between NREQ requesters.
// Optional watchdog (rsp_err output) enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 16,
  parameter int M    = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*N-1:0]       req_data,
  output logic [NREQ-1:0]         req_ack,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [M-1:0]            rsp_data,
  output logic                    busy,
`ifdef BCD_ARB_TIMEOUT_EN
  output logic                    rsp_err,
`endif
  output logic                    conv_new_data,
  output logic [N-1:0]            conv_data_in,
  input  logic                    conv_new_ack,
  input  logic                    conv_done,
  input  logic [M-1:0]            conv_data_out
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = IW + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT_DONE,
    RESP
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] rr_ptr, rr_next;
  logic [IW-1:0] gid;
  logic [IW-1:0] grant_idx;
  logic          grant_found;
  logic [SW-1:0] sum;
  logic [N-1:0]  op;
  logic [N-1:0]  ops [NREQ];
  logic          timeout;

  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign ops[g] = req_data[g*N +: N];
  end

  // Scan offsets from highest to lowest so the last hit is the first set bit at or after rr_ptr.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + SW'(i);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      if (req[sum[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[IW-1:0];
      end
    end
  end

  assign rr_next = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int LIMIT = 2 * N + 8;
  localparam int WW    = $clog2(LIMIT);

  logic [WW-1:0] wdog;

  // Counter is zero in the first ISSUE cycle, so timeout fires in the LIMIT-th cycle after ISSUE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state inside {ISSUE, SETTLE, WAIT_DONE}) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end

  assign timeout = (state inside {ISSUE, SETTLE, WAIT_DONE}) && (wdog == WW'(LIMIT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    req_ack       = '0;
    conv_new_data = 1'b0;
    conv_data_in  = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ack[grant_idx] = 1'b1;
          state_nx           = ISSUE;
        end
      end
      ISSUE: begin
        conv_new_data = 1'b1;
        conv_data_in  = op;
        if (timeout)           state_nx = RESP;
        else if (conv_new_ack) state_nx = SETTLE;
      end
      SETTLE: begin
        // conv_done may still be high from the converter's previous DONE state; ignore it here.
        state_nx = timeout ? RESP : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (conv_done || timeout) state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      op       <= '0;
      gid      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant_found) begin
        op     <= ops[grant_idx];
        gid    <= grant_idx;
        rr_ptr <= rr_next;
      end
      if (state == WAIT_DONE && conv_done) begin
        rsp_data <= conv_data_out;
        rsp_id   <= gid;
      end else if (timeout) begin
        rsp_data <= '0;
        rsp_id   <= gid;
      end
    end
  end

`ifdef BCD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (state == WAIT_DONE && conv_done) begin
      rsp_err <= 1'b0;
    end else if (timeout) begin
      rsp_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural shift-and-add-3 converter model.
`timescale 1ns/1ps
module tb_bcd_conv_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 16;
  localparam int M    = 20;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [M-1:0]      rsp_data;
  logic              busy;
`ifdef BCD_ARB_TIMEOUT_EN
  logic              rsp_err;
`endif
  logic              conv_new_data;
  logic [N-1:0]      conv_data_in;
  logic              conv_new_ack;
  logic              conv_done;
  logic [M-1:0]      conv_data_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bcd_conv_arbiter #(.NREQ(NREQ), .N(N), .M(M)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .busy          (busy),
`ifdef BCD_ARB_TIMEOUT_EN
    .rsp_err       (rsp_err),
`endif
    .conv_new_data (conv_new_data),
    .conv_data_in  (conv_data_in),
    .conv_new_ack  (conv_new_ack),
    .conv_done     (conv_done),
    .conv_data_out (conv_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: N shift cycles after the accepting edge, then DONE level until re-armed.
  typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_DONE} cstate_t;
  cstate_t      cst;
  int           ccnt;
  int           cwait;
  int           ack_delay  = 0;
  bit           never_done = 1'b0;
  logic [M-1:0] cres;

  function automatic logic [M-1:0] dd(input logic [N-1:0] b);
    logic [M-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      for (int d = 0; d < M / 4; d++)
        if (r[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
      r = {r[M-2:0], b[i]};
    end
    return r;
  endfunction

  assign conv_new_ack  = conv_new_data && (cst != C_SHIFT) && (cwait >= ack_delay);
  assign conv_done     = (cst == C_DONE);
  assign conv_data_out = (cst == C_DONE) ? cres : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cst   <= C_IDLE;
      ccnt  <= 0;
      cwait <= 0;
      cres  <= '0;
    end else if (conv_new_data && conv_new_ack) begin
      cst   <= C_SHIFT;
      ccnt  <= N;
      cwait <= 0;
      cres  <= dd(conv_data_in);
    end else begin
      if (conv_new_data) cwait <= cwait + 1;
      if (cst == C_SHIFT && !never_done) begin
        if (ccnt == 1) cst <= C_DONE;
        else           ccnt <= ccnt - 1;
      end
    end
  end

  // Event monitor, sampled 1ns after the falling edge.
  typedef struct { int c; logic [NREQ-1:0] v; } ack_t;
  typedef struct { int c; logic [IW-1:0] id; logic [M-1:0] d; logic e; } rsp_t;
  ack_t         ack_q[$];
  rsp_t         rsp_q[$];
  int           din_viol  = 0;
  int           stab_viol = 0;
  int           nd_cycles = 0;
  logic         prev_nd   = 1'b0;
  logic [N-1:0] prev_din  = '0;
  logic         err_s;

`ifdef BCD_ARB_TIMEOUT_EN
  assign err_s = rsp_err;
`else
  assign err_s = 1'b0;
`endif

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (req_ack != '0) ack_q.push_back('{c: cyc, v: req_ack});
      if (rsp_valid) rsp_q.push_back('{c: cyc, id: rsp_id, d: rsp_data, e: err_s});
      if (!conv_new_data && conv_data_in != '0) din_viol++;
      if (conv_new_data) begin
        nd_cycles++;
        if (prev_nd && conv_data_in !== prev_din) stab_viol++;
      end
    end
    prev_nd  = conv_new_data;
    prev_din = conv_data_in;
  end

  task automatic do_reset();
    req        = '0;
    req_data   = '0;
    ack_delay  = 0;
    never_done = 1'b0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ack_q.delete();
    rsp_q.delete();
    din_viol  = 0;
    stab_viol = 0;
    nd_cycles = 0;
  endtask

  task automatic wait_for(input bit on_rsp, input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (((on_rsp ? rsp_q.size() : ack_q.size()) < n) && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    ok = ((on_rsp ? rsp_q.size() : ack_q.size()) >= n);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    #3;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
    end
    checks++;
    if (rsp_id !== '0 || rsp_data !== '0 || req_ack !== '0) begin
      failures++;
      $display("FAIL reset_rsp id=%0d data=%h ack=%b expected zeros", rsp_id, rsp_data, req_ack);
    end
    checks++;
    if (conv_new_data !== 1'b0 || conv_data_in !== '0) begin
      failures++;
      $display("FAIL reset_conv new_data=%b data_in=%h expected 0 0", conv_new_data, conv_data_in);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    req_data[2*N +: N] = 16'd1234;
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    #2;
    checks++;
    if (busy !== 1'b1 || conv_new_data !== 1'b1 || conv_data_in !== 16'd1234) begin
      failures++;
      $display("FAIL single_issue busy=%b new_data=%b data_in=%0d expected 1 1 1234",
               busy, conv_new_data, conv_data_in);
    end
    wait_for(1'b1, 1, 40, ok);
    checks++;
    if (!ok || ack_q.size() != 1) begin
      failures++;
      $display("FAIL single_done rsp=%0d acks=%0d expected 1 1", rsp_q.size(), ack_q.size());
    end else begin
      checks++;
      if (ack_q[0].v !== 4'b0100) begin
        failures++;
        $display("FAIL single_ack got=%b expected=0100", ack_q[0].v);
      end
      checks++;
      if (rsp_q[0].c - ack_q[0].c != 19) begin
        failures++;
        $display("FAIL single_latency got=%0d expected=19", rsp_q[0].c - ack_q[0].c);
      end
      checks++;
      if (rsp_q[0].id !== 2'd2 || rsp_q[0].d !== 20'h01234 || rsp_q[0].e !== 1'b0) begin
        failures++;
        $display("FAIL single_rsp id=%0d data=%h err=%b expected 2 01234 0",
                 rsp_q[0].id, rsp_q[0].d, rsp_q[0].e);
      end
    end
  endtask

  task automatic test_all_four();
    bit           ok;
    int           exp_id [5] = '{0, 1, 2, 3, 0};
    logic [M-1:0] exp_d  [4] = '{20'h00000, 20'h00009, 20'h65535, 20'h00100};
    do_reset();
    req_data = {16'd100, 16'd65535, 16'd9, 16'd0};
    req      = 4'b1111;
    wait_for(1'b0, 5, 120, ok);
    @(negedge clk);
    req = '0;
    wait_for(1'b1, 5, 60, ok);
    checks++;
    if (!ok || ack_q.size() != 5) begin
      failures++;
      $display("FAIL all4_count rsp=%0d acks=%0d expected 5 5", rsp_q.size(), ack_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (ack_q[i].v !== (4'b0001 << exp_id[i])) begin
          failures++;
          $display("FAIL all4_grant%0d got=%b expected_id=%0d", i, ack_q[i].v, exp_id[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rsp_q[i].id !== IW'(exp_id[i]) || rsp_q[i].d !== exp_d[i]) begin
          failures++;
          $display("FAIL all4_rsp%0d id=%0d data=%h expected %0d %h",
                   i, rsp_q[i].id, rsp_q[i].d, exp_id[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    req_data[N +: N] = 16'd42;
    req = 4'b0010;
    wait_for(1'b0, 3, 80, ok);
    @(negedge clk);
    req = '0;
    wait_for(1'b1, 3, 60, ok);
    checks++;
    if (!ok || ack_q.size() != 3) begin
      failures++;
      $display("FAIL b2b_count rsp=%0d acks=%0d expected 3 3", rsp_q.size(), ack_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (ack_q[i].v !== 4'b0010 || ack_q[i].c - ack_q[i-1].c != 20) begin
          failures++;
          $display("FAIL b2b_spacing%0d ack=%b gap=%0d expected 0010 20",
                   i, ack_q[i].v, ack_q[i].c - ack_q[i-1].c);
        end
      end
      checks++;
      if (rsp_q[2].d !== 20'h00042 || rsp_q[2].id !== 2'd1) begin
        failures++;
        $display("FAIL b2b_rsp data=%h id=%0d expected 00042 1", rsp_q[2].d, rsp_q[2].id);
      end
    end
    checks++;
    if (din_viol != 0) begin
      failures++;
      $display("FAIL data_in_idle_zero violations=%0d expected 0", din_viol);
    end
  endtask

  task automatic test_delayed_ack();
    bit ok;
    do_reset();
    ack_delay = 5;
    req_data[3*N +: N] = 16'd9999;
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    wait_for(1'b1, 1, 50, ok);
    checks++;
    if (!ok || ack_q.size() != 1) begin
      failures++;
      $display("FAIL delay_done rsp=%0d acks=%0d expected 1 1", rsp_q.size(), ack_q.size());
    end else begin
      checks++;
      if (rsp_q[0].c - ack_q[0].c != 24) begin
        failures++;
        $display("FAIL delay_latency got=%0d expected=24", rsp_q[0].c - ack_q[0].c);
      end
      checks++;
      if (rsp_q[0].d !== 20'h09999 || rsp_q[0].id !== 2'd3) begin
        failures++;
        $display("FAIL delay_rsp data=%h id=%0d expected 09999 3", rsp_q[0].d, rsp_q[0].id);
      end
    end
    checks++;
    if (nd_cycles != 6 || stab_viol != 0) begin
      failures++;
      $display("FAIL delay_hold new_data_cycles=%0d unstable=%0d expected 6 0", nd_cycles, stab_viol);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    req_data[N +: N] = 16'd777;
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    repeat (8) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || conv_new_data !== 1'b0 ||
        conv_data_in !== '0 || rsp_data !== '0 || rsp_id !== '0 || req_ack !== '0) begin
      failures++;
      $display("FAIL midreset_outputs busy=%b rsp_valid=%b new_data=%b data=%h expected all 0",
               busy, rsp_valid, conv_new_data, rsp_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rsp_q.delete();
    ack_q.delete();
    repeat (25) @(negedge clk);
    checks++;
    if (rsp_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_no_rsp got=%0d expected=0", rsp_q.size());
    end
    req_data[N +: N]   = 16'd5;
    req_data[3*N +: N] = 16'd8;
    req = 4'b1010;
    @(negedge clk);
    req = '0;
    wait_for(1'b1, 1, 40, ok);
    checks++;
    if (!ok || ack_q.size() != 1) begin
      failures++;
      $display("FAIL midreset_next rsp=%0d acks=%0d expected 1 1", rsp_q.size(), ack_q.size());
    end else begin
      checks++;
      if (ack_q[0].v !== 4'b0010 || rsp_q[0].id !== 2'd1 || rsp_q[0].d !== 20'h00005) begin
        failures++;
        $display("FAIL midreset_rrptr ack=%b id=%0d data=%h expected 0010 1 00005",
                 ack_q[0].v, rsp_q[0].id, rsp_q[0].d);
      end
    end
  endtask

`ifdef BCD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    do_reset();
    never_done = 1'b1;
    req_data[15:0] = 16'd321;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    wait_for(1'b1, 1, 70, ok);
    checks++;
    if (!ok || ack_q.size() != 1) begin
      failures++;
      $display("FAIL timeout_done rsp=%0d acks=%0d expected 1 1", rsp_q.size(), ack_q.size());
    end else begin
      checks++;
      if (rsp_q[0].c - ack_q[0].c != 41) begin
        failures++;
        $display("FAIL timeout_latency got=%0d expected=41", rsp_q[0].c - ack_q[0].c);
      end
      checks++;
      if (rsp_q[0].e !== 1'b1 || rsp_q[0].d !== '0 || rsp_q[0].id !== 2'd0) begin
        failures++;
        $display("FAIL timeout_rsp err=%b data=%h id=%0d expected 1 00000 0",
                 rsp_q[0].e, rsp_q[0].d, rsp_q[0].id);
      end
    end
    do_reset();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_delayed_ack();
    test_reset_mid();
`ifdef BCD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
